// File: rtl/decoder_stim_sequencer_pkg.sv
// dec_stim_pkg: shared definitions for the decoder stimulus/checker stage.
//   state_t          FSM state encoding (IDLE/RUN/DONE)
//   MODE_*           sweep order selectors (2'b11 is reserved and acts as up)
//   CODE_W/ONEHOT_W  select-code and one-hot widths of the 3-to-8 decoder
//   code_to_onehot   reference one-hot pattern for a select code
package dec_stim_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;

  function automatic logic [ONEHOT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return {{(ONEHOT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/decoder_stim_sequencer_if.sv
// decoder_stim_sequencer_if: control and decoder-facing signals of the sequencer.
//   start, abort, mode   sweep control (driven by master)
//   onehot_in            decoder result sampled by the sequencer (driven by master)
//   code_out, code_valid select code sent to the decoder (driven by slave)
//   busy, done           sweep status (driven by slave)
//   err, err_count       sticky mismatch flag and saturating count (driven by slave)
interface decoder_stim_sequencer_if
  import dec_stim_pkg::*;
#(
  parameter int unsigned ERR_W = 4
);

  logic                start;
  logic                abort;
  logic [1:0]          mode;
  logic [ONEHOT_W-1:0] onehot_in;
  logic [CODE_W-1:0]   code_out;
  logic                code_valid;
  logic                busy;
  logic                done;
  logic                err;
  logic [ERR_W-1:0]    err_count;

  modport master (
    output start, abort, mode, onehot_in,
    input  code_out, code_valid, busy, done, err, err_count
  );

  modport slave (
    input  start, abort, mode, onehot_in,
    output code_out, code_valid, busy, done, err, err_count
  );

endinterface

// File: rtl/decoder_stim_sequencer_code_map.sv
// stim_code_map: maps a sweep position to the select code for the chosen order.
//   mode  sweep order (up / down / Gray; reserved value behaves as up)
//   idx   sweep position 0..7
//   code  select code to present to the decoder
module stim_code_map
  import dec_stim_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [CODE_W-1:0] idx,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = idx;
    case (mode)
      MODE_DOWN: code = ~idx;               // 7 - idx for a 3-bit index
      MODE_GRAY: code = idx ^ (idx >> 1);
      default:   code = idx;
    endcase
  end

endmodule

// File: rtl/decoder_stim_sequencer.sv
// decoder_stim_sequencer: clocked stimulus source and checker for a 3-to-8 decoder.
// Steps the select code through all eight values in the requested order, holding
// each for DWELL cycles, and compares the decoder's one-hot result in the last
// cycle of every dwell.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of decoder_stim_sequencer_if (control in, code/status out)
// Parameters: DWELL (2..255) cycles per code, ERR_W width of the error counter.
module decoder_stim_sequencer
  import dec_stim_pkg::*;
#(
  parameter int unsigned DWELL = 50,
  parameter int unsigned ERR_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  decoder_stim_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t            state;
  logic [1:0]        mode_q;
  logic [CODE_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic [1:0]        map_mode;
  logic [CODE_W-1:0] map_idx;
  logic [CODE_W-1:0] map_code;
  logic              dwell_end;
  logic              mismatch;

  // One mapper serves both cases: the first code of a new sweep (live mode,
  // position 0) and the next code within a running sweep (latched mode, idx+1).
  always_comb begin
    map_mode = mode_q;
    map_idx  = idx + CODE_W'(1);
    if (state == IDLE) begin
      map_mode = bus.mode;
      map_idx  = '0;
    end
  end

  stim_code_map u_code_map (
    .mode (map_mode),
    .idx  (map_idx),
    .code (map_code)
  );

  assign dwell_end = (state == RUN) && (cnt == CNT_LAST);
  assign mismatch  = dwell_end && (bus.onehot_in != code_to_onehot(code_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_UP;
      idx       <= '0;
      cnt       <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            mode_q    <= bus.mode;
            idx       <= '0;
            cnt       <= '0;
            code_q    <= map_code;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
          end
        end
        RUN: begin
          // The check result is recorded even when abort ends the sweep this cycle.
          if (mismatch) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
          end
          if (bus.abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (dwell_end) begin
            if (idx != '1) begin
              idx    <= idx + CODE_W'(1);
              cnt    <= '0;
              code_q <= map_code;
            end else begin
              state   <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_count  = err_cnt_q;

endmodule
